// File: rtl/key_pkg.sv
// Shared types and timing defaults for the key event decoder.
// States, 100 MHz timing constants and counter width helper.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } key_state_e;

  // 1 s, 150 ms and 100 ms at 100 MHz
  localparam int KEY_LONG_1S      = 100_000_000;
  localparam int KEY_GAP_150MS    = 15_000_000;
  localparam int KEY_REPEAT_100MS = 10_000_000;

  // one bit of headroom over the largest enabled period
  function automatic int key_cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Key polarity normalisation and press/release edge detection.
// Edge outputs are combinational from the current sample.
module key_edge_detect #(
  parameter int ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_level,
  output logic o_press_edge,
  output logic o_release_edge
);

  logic w_pressed;
  logic r_prev;

  assign w_pressed = i_key_level ^ (ACTIVE_LOW != 0);

  // previous pressed state, starts as released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_pressed;
  end

  assign o_press_edge   = w_pressed & ~r_prev;
  assign o_release_edge = ~w_pressed & r_prev;

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into click/long/held events.
// Define KEY_AUTOREPEAT_EN to add auto-repeat while held long.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int ACTIVE_LOW    = 0,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES    = KEY_GAP_150MS,
  parameter int REPEAT_CYCLES = KEY_REPEAT_100MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic key_held,
  output logic repeat_pulse
);

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_W = REPEAT_CYCLES;
`else
  // repeat period is unused without auto-repeat
  localparam int RPT_W = REPEAT_CYCLES * 0;
`endif

  localparam int CW = key_cnt_width(LONG_CYCLES, GAP_CYCLES, RPT_W);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  key_state_e    r_state;
  key_state_e    w_state_nx;
  logic [CW-1:0] r_cnt;
  logic          w_press_edge;
  logic          w_release_edge;
  logic          w_timed;
  logic          w_short_ev;
  logic          w_dbl_ev;
  logic          w_long_ev;
  logic          w_rpt_ev;

  logic r_press;
  logic r_release;
  logic r_short;
  logic r_dbl;
  logic r_long;
  logic r_held;
  logic r_rpt;

  key_edge_detect #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_edge (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_key_level   (key_level),
    .o_press_edge  (w_press_edge),
    .o_release_edge(w_release_edge)
  );

  assign w_timed = (r_state == ST_PRESS1) ||
                   (r_state == ST_WAIT2)  ||
                   (r_state == ST_PRESS2);

  // next state and event decode; edges beat timeouts
  always_comb begin
    w_state_nx = r_state;
    w_short_ev = 1'b0;
    w_dbl_ev   = 1'b0;
    w_long_ev  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_press_edge) w_state_nx = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (w_release_edge) begin
          w_state_nx = ST_WAIT2;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nx = ST_LONG;
          w_long_ev  = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (w_press_edge) begin
          w_state_nx = ST_PRESS2;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nx = ST_IDLE;
          w_short_ev = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (w_release_edge) begin
          w_state_nx = ST_IDLE;
          w_dbl_ev   = 1'b1;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nx = ST_LONG;
          w_long_ev  = 1'b1;
        end
      end
      ST_LONG: begin
        if (w_release_edge) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // state register and saturating per-state counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_state_nx != r_state)
        r_cnt <= '0;
      else if (w_timed && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rpt_cnt;
  logic          w_stay_long;

  assign w_stay_long = (r_state == ST_LONG) &&
                       (w_state_nx == ST_LONG);
  assign w_rpt_ev = w_stay_long && (r_rpt_cnt == RPT_LAST);

  // repeat period counter, only runs while staying in LONG
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rpt_cnt <= '0;
    else if (!w_stay_long || w_rpt_ev)
      r_rpt_cnt <= '0;
    else
      r_rpt_cnt <= r_rpt_cnt + 1'b1;
  end
`else
  assign w_rpt_ev = 1'b0;
`endif

  // registered event outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_dbl     <= 1'b0;
      r_long    <= 1'b0;
      r_held    <= 1'b0;
      r_rpt     <= 1'b0;
    end else begin
      r_press   <= w_press_edge;
      r_release <= w_release_edge;
      r_short   <= w_short_ev;
      r_dbl     <= w_dbl_ev;
      r_long    <= w_long_ev;
      r_held    <= (w_state_nx == ST_LONG);
      r_rpt     <= w_rpt_ev;
    end
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign short_click   = r_short;
  assign double_click  = r_dbl;
  assign long_press    = r_long;
  assign key_held      = r_held;
  assign repeat_pulse  = r_rpt;

endmodule
